// File: rtl/fp16_accum_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_accum_pkg                                                   |
// | Shared half-precision constants for the accumulator and adder.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fp16_accum_pkg;

    localparam logic [15:0] FP16_P_ZERO = 16'h0000;
    localparam logic [15:0] FP16_N_ZERO = 16'h8000;
    localparam logic [15:0] FP16_QNAN   = 16'h7E00;

endpackage : fp16_accum_pkg
`default_nettype wire

// File: rtl/fp16_add.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_add                                                         |
// | Pipelined half-precision adder: truncating, flush-to-zero,       |
// | denormal inputs treated as zero, NaN/Inf-Inf give quiet NaN.     |
// | Result valid LATENCY edges after the operands are presented.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fp16_add
    import fp16_accum_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    logic        sa, sb, s_big;
    logic [4:0]  ea, eb, e_big, e_sml, d, p;
    logic [9:0]  fa, fb, f_big, f_sml;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0] m_big, m_sml;
    logic [24:0] s, norm;
    int          e_res;
    logic [15:0] sum_w;
    logic [15:0] pipe_q [LATENCY];

    // Single-cycle combinational sum; magnitudes are aligned with 13 extra
    // fraction bits and the final fraction is truncated.
    always_comb begin
        sa     = a[15];
        sb     = b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        fa     = a[9:0];
        fb     = b[9:0];
        a_nan  = (ea == 5'h1F) && (fa != 10'h0);
        b_nan  = (eb == 5'h1F) && (fb != 10'h0);
        a_inf  = (ea == 5'h1F) && (fa == 10'h0);
        b_inf  = (eb == 5'h1F) && (fb == 10'h0);
        a_zero = (ea == 5'h0);
        b_zero = (eb == 5'h0);
        // Larger magnitude goes first so the subtraction never wraps
        if ({eb, fb} > {ea, fa}) begin
            s_big = sb; e_big = eb; f_big = fb; e_sml = ea; f_sml = fa;
        end else begin
            s_big = sa; e_big = ea; f_big = fa; e_sml = eb; f_sml = fb;
        end
        d     = e_big - e_sml;
        m_big = {1'b1, f_big, 13'h0};
        m_sml = {1'b1, f_sml, 13'h0} >> d;
        s     = (sa == sb) ? ({1'b0, m_big} + {1'b0, m_sml})
                           : ({1'b0, m_big} - {1'b0, m_sml});
        p = 5'd0;
        for (int i = 0; i < 25; i++) begin
            if (s[i]) p = 5'(i);
        end
        e_res = int'(e_big) + int'(p) - 23;
        norm  = s << (5'd24 - p);

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sum_w = FP16_QNAN;
        end else if (a_inf) begin
            sum_w = a;
        end else if (b_inf) begin
            sum_w = b;
        end else if (a_zero && b_zero) begin
            sum_w = (sa && sb) ? FP16_N_ZERO : FP16_P_ZERO;
        end else if (a_zero) begin
            sum_w = b;
        end else if (b_zero) begin
            sum_w = a;
        end else if (s == 25'h0) begin
            sum_w = FP16_P_ZERO;
        end else if (e_res >= 31) begin
            sum_w = {s_big, 5'h1F, 10'h0};
        end else if (e_res <= 0) begin
            sum_w = {s_big, 15'h0};
        end else begin
            sum_w = {s_big, 5'(e_res), 10'(norm >> 14)};
        end
    end

    // Delay line that sets the adder latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= sum_w;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[LATENCY-1];

endmodule : fp16_add
`default_nettype wire

// File: rtl/fp16_accum.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_accum                                                       |
// | Streams half-precision operands into a running sum; in_last      |
// | closes the sum, which is offered with its operand count.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fp16_accum
    import fp16_accum_pkg::*;
#(
    parameter int ADD_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int WCNT_W = (ADD_LATENCY < 2) ? 1 : $clog2(ADD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       acc_q, acc_d, op_q, op_d;
    logic              last_q, last_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [15:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic [15:0]       add_result;
    logic              accept;

    fp16_add #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (acc_q),
        .b      (op_q),
        .result (add_result)
    );

    assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and datapath updates; the published result is latched
    // whenever the machine is (or stays) in DONE so it holds afterwards.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // First operand loads directly so -0 survives
                    acc_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    op_d    = in_data;
                    last_d  = in_last;
                    wcnt_d  = WCNT_W'(ADD_LATENCY);
                    cnt_d   = cnt_inc;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    acc_d   = add_result;
                    state_d = last_q ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) begin
            out_data_d  = acc_d;
            out_count_d = cnt_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            last_q      <= 1'b0;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

endmodule : fp16_accum
`default_nettype wire

// File: tb/tb_fp16_accum.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp16_accum                                                    |
// | Directed bench for fp16_accum with a result scoreboard.          |
// | A small counter width is used so saturation is reachable.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fp16_accum;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    fp16_accum #(
        .ADD_LATENCY (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one beat and hold it until accepted; returns 1 time unit after the accept edge
    task automatic send(input logic [15:0] d, input logic last);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        logic got;
        got = out_valid;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk);
            #1;
            got = out_valid;
        end
        if (!got) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake is matched against the oldest expected sum
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {out_data, 16'(out_count)}, 32'hFFFF_FFFF);
            end else begin
                chk("sum", {out_data, 16'(out_count)}, sb.pop_front());
            end
        end
    end

    initial begin
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        #20;
        rst_n = 1'b1;
        cycles(1);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 1.0 + 2.0 + 0.5 = 3.5, plus per-operand timing
        sb.push_back({16'h4300, 16'd3});
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        chk("wait_busy", 32'(busy), 32'd1);
        k = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) break;
            k++;
        end
        chk("ready_low_cycles", 32'(k), 32'd3);
        @(posedge clk);
        #1;
        send(16'h3800, 1'b1);
        wait_valid();
        cycles(1);
        chk("valid_one_cycle", 32'(out_valid), 32'd0);

        // Single negative zero passes through unchanged
        sb.push_back({16'h8000, 16'd1});
        send(16'h8000, 1'b1);
        chk("single_valid_next", 32'(out_valid), 32'd1);
        cycles(2);

        // Inf - Inf and overflow
        sb.push_back({16'h7E00, 16'd2});
        send(16'h7C00, 1'b0);
        send(16'hFC00, 1'b1);
        wait_valid();
        cycles(1);

        // Back-pressure in DONE: result held, new beats refused
        out_ready = 1'b0;
        sb.push_back({16'h7C00, 16'd2});
        send(16'h7BFF, 1'b0);
        send(16'h7BFF, 1'b1);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("hold_data",  {out_data, 16'(out_count)}, {16'h7C00, 16'd2});
            chk("hold_ready", 32'({in_ready, out_valid}), 32'b01);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycles(1);
        chk("idle_after_handshake", 32'({busy, out_valid}), 32'd0);

        // Reset in the middle of a sum discards it
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {out_data, 16'(out_count)}, 32'd0);
        chk("midrst_flags", 32'({out_valid, in_ready, busy}), 32'd0);
        #12;
        rst_n = 1'b1;
        cycles(6);
        chk("no_valid_after_rst", 32'(out_valid), 32'd0);
        sb.push_back({16'h4400, 16'd2});
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b1);
        wait_valid();
        cycles(1);

        // Count saturation: seventeen ones -> 17.0, count pinned at 15
        sb.push_back({16'h4C40, 16'd15});
        for (int n = 0; n < 17; n++) send(16'h3C00, (n == 16));
        wait_valid();
        cycles(1);

        // Random gaps: twelve ones -> 12.0, never ready while the add is pending
        sb.push_back({16'h4A00, 16'd12});
        for (int n = 0; n < 12; n++) begin
            cycles($urandom_range(0, 3));
            send(16'h3C00, (n == 11));
            if (n != 0 && n != 11) chk("no_ready_in_wait", 32'(in_ready), 32'd0);
        end
        wait_valid();
        cycles(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp16_accum
`default_nettype wire
